// File: rtl/risc_pkg.sv
// Shared definitions for the fetch front end: decodable opcodes and fetch FSM states.
package risc_pkg;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_HALT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_MEM,
        ST_DISPATCH,
        ST_EXEC,
        ST_HALT
    } fetch_state_t;

    // Opcodes the controller can execute; anything else must never reach it.
    function automatic logic is_exec_opc(input logic [2:0] opc);
        return (opc == OPC_MOV) || (opc == OPC_ALU);
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Loadable program counter that wraps modulo 2**ADDR_W; load has priority over increment.
module pc_counter #(
    parameter int              ADDR_W   = 9,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset)
            pc <= RESET_PC;
        else if (load)
            pc <= load_val;
        else if (inc)
            pc <= pc + 1'b1;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: fetches, screens and hands instructions to the datapath
// controller via the s/w handshake, with HALT handling and memory timeout detection.
module instr_fetch_unit #(
    parameter int ADDR_W   = 9,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid,
    input  logic              ctl_w,
    output logic              ctl_s,
    output logic [15:0]       ir,
    output logic [ADDR_W-1:0] pc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic              halted,
    output logic              fetch_err
);
    import risc_pkg::*;

    fetch_state_t state;
    logic [7:0]   wait_cnt;
    logic [7:0]   cnt_next;
    logic         busy_seen;
    logic         pc_inc;
    logic         pc_ld;

    assign cnt_next = wait_cnt + 8'd1;
    assign pc_inc   = (state == ST_WAIT_MEM) && mem_rvalid;
    // Redirects are honoured only while nothing is in flight.
    assign pc_ld    = pc_load && ((state == ST_IDLE) || (state == ST_HALT));

    assign mem_req  = (state == ST_FETCH);
    assign ctl_s    = (state == ST_DISPATCH);
    assign mem_addr = pc;

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (ADDR_W'(RESET_PC))
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .inc      (pc_inc),
        .load     (pc_ld),
        .load_val (pc_target),
        .pc       (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ir        <= '0;
            wait_cnt  <= '0;
            busy_seen <= 1'b0;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!pc_load && run && ctl_w)
                        state <= ST_FETCH;
                end
                ST_FETCH: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT_MEM;
                end
                ST_WAIT_MEM: begin
                    wait_cnt <= cnt_next;
                    // A strobe arriving on the last allowed cycle still wins over the timeout.
                    if (mem_rvalid) begin
                        ir <= mem_rdata;
                        if (is_exec_opc(mem_rdata[15:13])) begin
                            state <= ST_DISPATCH;
                        end else begin
                            state <= ST_HALT;
                            if (mem_rdata[15:13] == OPC_HALT)
                                halted <= 1'b1;
                            else
                                fetch_err <= 1'b1;
                        end
                    end else if (cnt_next == 8'(TIMEOUT)) begin
                        state     <= ST_HALT;
                        fetch_err <= 1'b1;
                    end
                end
                ST_DISPATCH: begin
                    busy_seen <= 1'b0;
                    state     <= ST_EXEC;
                end
                ST_EXEC: begin
                    // Completion needs the controller to have left and re-entered its wait state.
                    if (!ctl_w)
                        busy_seen <= 1'b1;
                    else if (busy_seen)
                        state <= run ? ST_FETCH : ST_IDLE;
                end
                ST_HALT: begin
                    if (pc_load) begin
                        halted    <= 1'b0;
                        fetch_err <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations, then randomized
// traffic against a behavioural model of the fetch protocol, compared every cycle.
module tb_instr_fetch_unit;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 15;
    localparam int M_IDLE = 0, M_FETCH = 1, M_WAIT = 2, M_DISP = 3, M_EXEC = 4, M_HALT = 5;

    logic              clk = 1'b0;
    logic              reset, run, mem_req, mem_rvalid, ctl_w, ctl_s, pc_load, halted, fetch_err;
    logic [ADDR_W-1:0] mem_addr, pc, pc_target;
    logic [15:0]       mem_rdata, ir;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(0), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .run(run), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .ctl_w(ctl_w), .ctl_s(ctl_s),
        .ir(ir), .pc(pc), .pc_load(pc_load), .pc_target(pc_target),
        .halted(halted), .fetch_err(fetch_err)
    );

    int  vectors = 0, miscompares = 0;
    bit  chk_en = 1'b0;
    logic [15:0] mem [0:511];

    // behavioural model
    int          m_mode = M_IDLE, m_pc = 0, m_waited = 0;
    logic [15:0] m_ir = '0;
    bit          m_halted = 1'b0, m_err = 1'b0, m_busy = 1'b0;

    // environment: memory and controller
    bit pend = 1'b0, rand_mode = 1'b0, force_rv = 1'b0;
    int k = 0, lat = 1, raddr = 0, busy_left = 0, fixed_lat = 1, fixed_busy = 2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rand_instr();
        int r = $urandom_range(0, 19);
        logic [12:0] low = 13'($urandom);
        if (r < 9)        return {3'b110, low};
        else if (r < 18)  return {3'b101, low};
        else if (r == 18) return {3'b111, low};
        else              return {3'($urandom_range(0, 4)), low};
    endfunction

    function automatic int rand_lat();
        int r = $urandom_range(0, 99);
        if (r < 80)      return $urandom_range(1, 3);
        else if (r < 88) return TIMEOUT;
        else if (r < 94) return TIMEOUT + 1;
        else             return 0;
    endfunction

    task automatic model_step();
        int op;
        if (reset) begin
            m_mode = M_IDLE; m_pc = 0; m_ir = '0; m_halted = 0; m_err = 0; m_waited = 0; m_busy = 0;
            return;
        end
        case (m_mode)
            M_IDLE: if (pc_load) m_pc = int'(pc_target);
                    else if (run && ctl_w) m_mode = M_FETCH;
            M_FETCH: begin m_waited = 0; m_mode = M_WAIT; end
            M_WAIT: begin
                m_waited++;
                if (mem_rvalid) begin
                    m_ir = mem_rdata;
                    m_pc = (m_pc + 1) % (1 << ADDR_W);
                    op   = int'(mem_rdata[15:13]);
                    if (op == 6 || op == 5) m_mode = M_DISP;
                    else begin
                        m_mode = M_HALT;
                        if (op == 7) m_halted = 1; else m_err = 1;
                    end
                end else if (m_waited == TIMEOUT) begin
                    m_mode = M_HALT; m_err = 1;
                end
            end
            M_DISP: begin m_busy = 0; m_mode = M_EXEC; end
            M_EXEC: if (!ctl_w) m_busy = 1;
                    else if (m_busy) m_mode = run ? M_FETCH : M_IDLE;
            default: if (pc_load) begin
                m_pc = int'(pc_target); m_halted = 0; m_err = 0; m_mode = M_IDLE;
            end
        endcase
    endtask

    // Drives memory response and controller w for the coming clock edge from the model's view.
    task automatic env_drive();
        mem_rvalid = 1'b0;
        mem_rdata  = 16'($urandom);
        if (m_mode == M_FETCH) begin
            pend = 1; k = 0; raddr = m_pc;
            lat  = (fixed_lat >= 0) ? fixed_lat : rand_lat();
        end else if (pend) begin
            if (m_mode != M_WAIT) pend = 0;
            else begin
                k++;
                if (lat != 0 && k == lat) begin
                    mem_rvalid = 1'b1; mem_rdata = mem[raddr]; pend = 0;
                end
            end
        end else if (rand_mode && m_mode != M_WAIT && $urandom_range(0, 19) == 0) begin
            mem_rvalid = 1'b1;
        end
        if (force_rv) begin mem_rvalid = 1'b1; mem_rdata = 16'hD105; end
        if (m_mode == M_DISP) begin
            busy_left = (fixed_busy > 0) ? fixed_busy : $urandom_range(1, 4);
            ctl_w = 1'b1;
        end else if (busy_left > 0) begin
            ctl_w = 1'b0; busy_left--;
        end else begin
            ctl_w = (rand_mode && m_mode == M_IDLE) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        env_drive();
        @(posedge clk);
        #1;
        model_step();
    endtask

    function automatic bit sig(input int which);
        case (which)
            0: return mem_req === 1'b1;
            1: return ctl_s === 1'b1;
            2: return halted === 1'b1;
            default: return fetch_err === 1'b1;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, output int n);
        n = 0;
        do begin cyc(); n++; end while (!sig(which) && n < budget);
        if (!sig(which)) begin
            vectors++; miscompares++;
            $display("FAIL wait_%0d: event not seen within %0d cycles", which, budget);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req",   32'(mem_req),   32'(m_mode == M_FETCH));
            chk("ctl_s",     32'(ctl_s),     32'(m_mode == M_DISP));
            chk("mem_addr",  32'(mem_addr),  32'(m_pc));
            chk("pc",        32'(pc),        32'(m_pc));
            chk("ir",        32'(ir),        32'(m_ir));
            chk("halted",    32'(halted),    32'(m_halted));
            chk("fetch_err", 32'(fetch_err), 32'(m_err));
        end
    end

    initial begin
        int n, cnt;
        reset = 1; run = 0; pc_load = 0; pc_target = '0;
        mem_rvalid = 0; mem_rdata = '0; ctl_w = 1;
        for (int i = 0; i < 512; i++) mem[i] = rand_instr();
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_pc", 32'(pc), 0);       chk("rst_ir", 32'(ir), 0);
        chk("rst_req", 32'(mem_req), 0); chk("rst_s", 32'(ctl_s), 0);
        chk("rst_halt", 32'(halted), 0); chk("rst_err", 32'(fetch_err), 0);

        // basic fetch and dispatch, 1-cycle memory
        mem[0] = 16'hD105; mem[1] = 16'hA123; mem[2] = 16'hE000;
        reset = 0; run = 1;
        wait_for(0, 20, n); chk("t1_addr0", 32'(mem_addr), 0);
        wait_for(1, 20, n); chk("t1_ir", 32'(ir), 32'hD105); chk("t1_pc", 32'(pc), 1);
        wait_for(0, 20, n); chk("t1_addr1", 32'(mem_addr), 1);

        // HALT instruction then redirect
        wait_for(2, 40, n); chk("t2_pc", 32'(pc), 3); chk("t2_ir", 32'(ir), 32'hE000);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin cyc(); cnt += int'(mem_req); end
        chk("t2_noreq", 32'(cnt), 0);
        mem[0] = 16'h0000;
        pc_load = 1; pc_target = '0; cyc(); pc_load = 0;
        chk("t2_unhalt", 32'(halted), 0); chk("t2_pc0", 32'(pc), 0);
        wait_for(0, 20, n); chk("t2_addr0", 32'(mem_addr), 0);

        // illegal opcode
        wait_for(3, 20, n);
        chk("t3_err", 32'(fetch_err), 1); chk("t3_halt", 32'(halted), 0); chk("t3_pc", 32'(pc), 1);

        // timeout: 15 WAIT_MEM cycles without strobe, then HALT
        fixed_lat = 0;
        pc_load = 1; pc_target = 9'd5; cyc(); pc_load = 0;
        chk("t4_errclr", 32'(fetch_err), 0);
        wait_for(0, 20, n); chk("t4_addr5", 32'(mem_addr), 5);
        wait_for(3, 40, n); chk("t4_tmo_cycles", 32'(n), 32'(TIMEOUT + 1)); chk("t4_pc", 32'(pc), 5);
        mem[5] = 16'hC0DE; fixed_lat = TIMEOUT;
        pc_load = 1; cyc(); pc_load = 0;
        wait_for(0, 20, n);
        wait_for(1, 40, n);
        chk("t4_late_err", 32'(fetch_err), 0); chk("t4_late_ir", 32'(ir), 32'hC0DE);
        chk("t4_late_pc", 32'(pc), 6);

        // wrap at top of address space, then run dropped mid-instruction
        mem[6] = 16'hE000; mem[511] = 16'hA5A5; fixed_lat = 1;
        wait_for(2, 40, n);
        pc_load = 1; pc_target = 9'd511; cyc(); pc_load = 0;
        wait_for(1, 20, n); chk("t5_wrap", 32'(pc), 0); chk("t5_ir", 32'(ir), 32'hA5A5);
        run = 0; fixed_busy = 3; cnt = 0;
        for (int i = 0; i < 12; i++) begin cyc(); cnt += int'(mem_req); end
        chk("t5_noreq", 32'(cnt), 0);

        // reset while waiting on memory, stray strobe afterwards
        run = 1; fixed_lat = 2;
        wait_for(0, 20, n);
        cyc();
        reset = 1; run = 0; cyc();
        reset = 0; force_rv = 1; cyc(); force_rv = 0;
        chk("t6_ir", 32'(ir), 0); chk("t6_pc", 32'(pc), 0);
        chk("t6_req", 32'(mem_req), 0); chk("t6_s", 32'(ctl_s), 0);
        chk("t6_halt", 32'(halted), 0); chk("t6_err", 32'(fetch_err), 0);

        // randomized traffic
        rand_mode = 1; fixed_lat = -1; fixed_busy = 0;
        for (int i = 0; i < 512; i++) mem[i] = rand_instr();
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            run       = ($urandom_range(0, 9) != 0);
            pc_load   = (m_mode == M_HALT) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
            pc_target = ADDR_W'($urandom);
            cyc();
        end
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
